dual_port_ram_bist: RTL and testbench



---
 rtl/bram_pkg.sv | 34 +++
 rtl/bist_delay_line.sv | 34 +++
 rtl/dual_port_ram_bist.sv | 165 ++++++++++++++++
 tb/tb_dual_port_ram_bist.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared types and the data-pattern generator for the BRAM self-test.
package bram_pkg;

  localparam int PAT_W = 64;

  localparam logic [1:0] PAT_ADDR = 2'd0;
  localparam logic [1:0] PAT_INV  = 2'd1;
  localparam logic [1:0] PAT_CHK  = 2'd2;
  localparam logic [1:0] PAT_ONES = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } bist_state_e;

  // Result is wide; callers size-cast to their data width, which gives the
  // zero-extend/truncate behaviour for the address patterns.
  function automatic logic [PAT_W-1:0] pattern_word(input logic [PAT_W-1:0] addr,
                                                    input logic [1:0]       sel);
    logic [PAT_W-1:0] w;
    w = '1;
    case (sel)
      PAT_ADDR: w = addr;
      PAT_INV:  w = ~addr;
      PAT_CHK:  w = addr[0] ? {(PAT_W/2){2'b10}} : {(PAT_W/2){2'b01}};
      default:  w = '1;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/bist_delay_line.sv
// Tag pipeline that tracks which address each returning read word belongs to.
module bist_delay_line #(
  parameter int STAGES = 1,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              vld_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              vld_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic [STAGES-1:0]             vld_pipe_q;
  logic [STAGES-1:0][ADDR_W-1:0] addr_pipe_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe_q  <= '0;
      addr_pipe_q <= '0;
    end else begin
      vld_pipe_q[0]  <= vld_i;
      addr_pipe_q[0] <= addr_i;
      for (int i = 1; i < STAGES; i++) begin
        vld_pipe_q[i]  <= vld_pipe_q[i-1];
        addr_pipe_q[i] <= addr_pipe_q[i-1];
      end
    end
  end

  assign vld_o  = vld_pipe_q[STAGES-1];
  assign addr_o = addr_pipe_q[STAGES-1];

endmodule

// File: rtl/dual_port_ram_bist.sv
// BRAM self-test initiator: fill via port A, read back via port B, count mismatches.
// All RAM-facing and status outputs are registered one cycle behind the FSM state.
module dual_port_ram_bist
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [1:0]            pattern_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   error_count,
  output logic [ADDR_WIDTH-1:0] fail_address,
  output logic                  write_enable_A,
  output logic [DATA_WIDTH-1:0] data_in_A,
  output logic [ADDR_WIDTH-1:0] address_A,
  output logic                  write_enable_B,
  output logic [DATA_WIDTH-1:0] data_in_B,
  output logic [ADDR_WIDTH-1:0] address_B,
  input  logic [DATA_WIDTH-1:0] data_out_B
);

  localparam int CW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  bist_state_e state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [1:0]            drain_q, drain_d;
  logic [1:0]            sel_q, sel_d;
  logic                  accept;

  logic                  we_a_q, rd_vld_q, busy_q, done_q;
  logic                  pass_q, pass_d;
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_b_q;
  logic [DATA_WIDTH-1:0] din_a_q, wr_pat, cmp_pat;
  logic [CW-1:0]         err_q, err_d;
  logic [ADDR_WIDTH-1:0] fail_q, fail_d;

  logic                  tag_vld;
  logic [ADDR_WIDTH-1:0] tag_addr;
  logic                  mismatch;

  assign accept  = (state_q == S_IDLE) && start;
  assign cnt_inc = cnt_q + 1'b1;
  assign wr_pat  = DATA_WIDTH'(pattern_word(PAT_W'(cnt_q[ADDR_WIDTH-1:0]), sel_q));
  assign cmp_pat = DATA_WIDTH'(pattern_word(PAT_W'(tag_addr), sel_q));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_WRITE;
        cnt_d   = '0;
        sel_d   = pattern_sel;
      end
      S_WRITE: begin
        cnt_d = cnt_inc;
        // carry into the extra counter bit marks the last address
        if (cnt_inc[ADDR_WIDTH]) begin
          state_d = S_READ;
          cnt_d   = '0;
        end
      end
      S_READ: begin
        cnt_d = cnt_inc;
        if (cnt_inc[ADDR_WIDTH]) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
          drain_d = '0;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == 2'(READ_LATENCY - 1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  bist_delay_line #(
    .STAGES (READ_LATENCY),
    .ADDR_W (ADDR_WIDTH)
  ) u_tag_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .vld_i   (rd_vld_q),
    .addr_i  (addr_b_q),
    .vld_o   (tag_vld),
    .addr_o  (tag_addr)
  );

  assign mismatch = tag_vld && (data_out_B != cmp_pat);

  always_comb begin
    err_d  = err_q;
    fail_d = fail_q;
    pass_d = pass_q;
    if (accept) begin
      err_d  = '0;
      fail_d = '0;
      pass_d = 1'b0;
    end else begin
      if (mismatch && (err_q != CW'(DEPTH))) err_d = err_q + 1'b1;
      if (mismatch && (err_q == '0))         fail_d = tag_addr;
      // the last compare can land on the same edge, so use the next count
      if (state_q == S_DONE)                 pass_d = (err_d == '0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      drain_q  <= '0;
      sel_q    <= '0;
      we_a_q   <= 1'b0;
      addr_a_q <= '0;
      din_a_q  <= '0;
      addr_b_q <= '0;
      rd_vld_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fail_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
      sel_q    <= sel_d;
      we_a_q   <= (state_q == S_WRITE);
      addr_a_q <= (state_q == S_WRITE) ? cnt_q[ADDR_WIDTH-1:0] : '0;
      din_a_q  <= (state_q == S_WRITE) ? wr_pat : '0;
      addr_b_q <= (state_q == S_READ) ? cnt_q[ADDR_WIDTH-1:0] : '0;
      rd_vld_q <= (state_q == S_READ);
      busy_q   <= (state_q != S_IDLE);
      done_q   <= (state_q == S_DONE);
      pass_q   <= pass_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign error_count    = err_q;
  assign fail_address   = fail_q;
  assign write_enable_A = we_a_q;
  assign data_in_A      = din_a_q;
  assign address_A      = addr_a_q;
  assign write_enable_B = 1'b0;
  assign data_in_B      = '0;
  assign address_B      = addr_b_q;

endmodule

// File: tb/tb_dual_port_ram_bist.sv
// Directed bench: two BIST instances (read latency 1 and 2) against behavioural RAMs.
module tb_dual_port_ram_bist;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // DUT1: READ_LATENCY = 1
  logic       start1 = 1'b0;
  logic [1:0] sel1 = 2'd0;
  logic       busy1, done1, pass1, we_a1, we_b1;
  logic [8:0] err1;
  logic [7:0] fail1, din_a1, addr_a1, din_b1, addr_b1, dout1;

  // DUT2: READ_LATENCY = 2
  logic       start2 = 1'b0;
  logic [1:0] sel2 = 2'd0;
  logic       busy2, done2, pass2, we_a2, we_b2;
  logic [8:0] err2;
  logic [7:0] fail2, din_a2, addr_a2, din_b2, addr_b2, dout2, rd2_stage;

  int ram_mode = 0;  // 0 normal, 1 flip bit 3 on address 0x42, 2 read data stuck at 0
  logic [7:0] mem1 [256];
  logic [7:0] mem2 [256];

  dual_port_ram_bist #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .READ_LATENCY(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start1), .pattern_sel(sel1),
    .busy(busy1), .done(done1), .pass(pass1), .error_count(err1), .fail_address(fail1),
    .write_enable_A(we_a1), .data_in_A(din_a1), .address_A(addr_a1),
    .write_enable_B(we_b1), .data_in_B(din_b1), .address_B(addr_b1), .data_out_B(dout1));

  dual_port_ram_bist #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .READ_LATENCY(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .start(start2), .pattern_sel(sel2),
    .busy(busy2), .done(done2), .pass(pass2), .error_count(err2), .fail_address(fail2),
    .write_enable_A(we_a2), .data_in_A(din_a2), .address_A(addr_a2),
    .write_enable_B(we_b2), .data_in_B(din_b2), .address_B(addr_b2), .data_out_B(dout2));

  always @(posedge clock) begin
    if (we_a1) mem1[addr_a1] <= din_a1;
    if (ram_mode == 2)
      dout1 <= 8'h00;
    else if (ram_mode == 1 && addr_b1 == 8'h42)
      dout1 <= mem1[addr_b1] ^ 8'h08;
    else
      dout1 <= mem1[addr_b1];
  end

  always @(posedge clock) begin
    if (we_a2) mem2[addr_a2] <= din_a2;
    rd2_stage <= mem2[addr_b2];
    dout2     <= rd2_stage;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start a test on dut1; pattern_sel is scrambled mid-run to prove it is latched.
  task automatic run1(input logic [1:0] sel, input int restart_at, output int lat, output int ndone);
    sel1 = sel; start1 = 1'b1;
    @(posedge clock); #1;
    start1 = 1'b0;
    lat = -1; ndone = 0;
    for (int n = 1; n <= 600; n++) begin
      start1 = (n == restart_at);
      if (n == 10) sel1 = ~sel;
      @(posedge clock); #1;
      if (done1) begin
        ndone++;
        if (lat < 0) lat = n;
      end
    end
    start1 = 1'b0;
  endtask

  task automatic run2(input logic [1:0] sel, output int lat, output int ndone);
    sel2 = sel; start2 = 1'b1;
    @(posedge clock); #1;
    start2 = 1'b0;
    lat = -1; ndone = 0;
    for (int n = 1; n <= 600; n++) begin
      @(posedge clock); #1;
      if (done2) begin
        ndone++;
        if (lat < 0) lat = n;
      end
    end
  endtask

  initial begin
    int lat, nd;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_pass", 32'(pass1), 32'd0);
    chk("rst_err",  32'(err1),  32'd0);
    chk("rst_fail", 32'(fail1), 32'd0);
    chk("rst_we_a", 32'(we_a1), 32'd0);
    chk("rst_addr_a", 32'(addr_a1), 32'd0);
    chk("rst_din_a",  32'(din_a1),  32'd0);
    chk("rst_addr_b", 32'(addr_b1), 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // clean RAM, address pattern, extra start at cycle 100 must be ignored
    run1(2'd0, 100, lat, nd);
    chk("lat_sel0",   32'(lat),  32'd514);
    chk("ndone_sel0", 32'(nd),   32'd1);
    chk("pass_sel0",  32'(pass1), 32'd1);
    chk("err_sel0",   32'(err1),  32'd0);
    chk("fail_sel0",  32'(fail1), 32'd0);
    chk("mem42_sel0", 32'(mem1[8'h42]), 32'h42);
    chk("port_b_idle", 32'({we_b1, din_b1}), 32'd0);

    // single bad bit at 0x42, checkerboard
    ram_mode = 1;
    run1(2'd2, 0, lat, nd);
    chk("pass_flip", 32'(pass1), 32'd0);
    chk("err_flip",  32'(err1),  32'd1);
    chk("fail_flip", 32'(fail1), 32'h42);
    chk("mem43_chk", 32'(mem1[8'h43]), 32'hAA);

    // read data stuck at zero: inverted address matches only at 0xFF
    ram_mode = 2;
    run1(2'd1, 0, lat, nd);
    chk("err_stuck_inv",  32'(err1),  32'd255);
    chk("fail_stuck_inv", 32'(fail1), 32'd0);
    chk("pass_stuck_inv", 32'(pass1), 32'd0);

    // all ones vs stuck zero: every word fails, count saturates
    run1(2'd3, 0, lat, nd);
    chk("err_stuck_ones", 32'(err1), 32'd256);
    chk("lat_stuck_ones", 32'(lat),  32'd514);
    ram_mode = 0;

    // reset in the middle of the write phase
    sel1 = 2'd0; start1 = 1'b1;
    @(posedge clock); #1;
    start1 = 1'b0;
    repeat (49) @(posedge clock);
    #1;
    chk("we_a_mid",  32'(we_a1), 32'd1);
    chk("busy_mid",  32'(busy1), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("we_a_rst",  32'(we_a1), 32'd0);
    chk("busy_rst",  32'(busy1), 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    run1(2'd0, 0, lat, nd);
    chk("lat_after_rst",  32'(lat),   32'd514);
    chk("pass_after_rst", 32'(pass1), 32'd1);

    // two-stage RAM on dut2
    run2(2'd0, lat, nd);
    chk("lat_rl2",   32'(lat),  32'd515);
    chk("ndone_rl2", 32'(nd),   32'd1);
    chk("pass_rl2",  32'(pass2), 32'd1);
    chk("err_rl2",   32'(err2),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
